// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) matrix engine: FSM encoding and
// index/identity helpers for row-major flat matrices (element (i,j) at bit i*N+j).
package gf2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Flat bit position of element (i,j) in an n x n row-major matrix.
    function automatic int elem_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    // Bit value of the identity matrix at flat position idx (1 on the diagonal).
    function automatic logic ident_bit(input int idx, input int n);
        return (idx / n) == (idx % n);
    endfunction

endpackage

// File: rtl/gf2_matrix_pow_matrix_mul.sv
// Combinational GF(2) matrix product p = a x b: AND for multiply, XOR for add.
module matrix_mul
    import gf2_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [0:N*N-1] a,
    input  logic [0:N*N-1] b,
    output logic [0:N*N-1] p
);

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [N-1:0] terms;
            for (genvar gk = 0; gk < N; gk++) begin : g_term
                assign terms[gk] = a[elem_idx(gi, gk, N)] & b[elem_idx(gk, gj, N)];
            end
            // Each result bit is the parity of the N partial products; no carries.
            assign p[elem_idx(gi, gj, N)] = ^terms;
        end
    end

endmodule

// File: rtl/gf2_matrix_pow.sv
// Sequential GF(2) matrix engine: single product A x B, or A^e by
// right-to-left square-and-multiply, one exponent bit per clock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds in_valid and its operands until it sees
// in_ready; out_mat stays stable while out_valid is high until out_ready.
module gf2_matrix_pow
    import gf2_pkg::*;
#(
    parameter int N     = 4,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [0:N*N-1]   in_mat_a,
    input  logic [0:N*N-1]   in_mat_b,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:N*N-1]   out_mat,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int NN = N * N;

    state_t           state_q;
    state_t           state_d;
    logic [0:NN-1]    base_r;
    logic [0:NN-1]    acc_r;
    logic [EXP_W-1:0] exp_r;
    logic [EXP_W-1:0] exp_shift;
    logic [0:NN-1]    ident;
    logic [0:NN-1]    mul_a;
    logic [0:NN-1]    mul_b;
    logic [0:NN-1]    prod_ab;
    logic [0:NN-1]    prod_sq;
    logic             accept;

    for (genvar g = 0; g < NN; g++) begin : g_ident
        assign ident[g] = ident_bit(g, N);
    end

    assign exp_shift = exp_r >> 1;
    assign accept    = (state_q == IDLE) && in_valid;

    // In IDLE the first multiplier forms the request product A x B; in RUN it
    // forms acc x base, so one multiplier serves both operations.
    assign mul_a = (state_q == IDLE) ? in_mat_a : acc_r;
    assign mul_b = (state_q == IDLE) ? in_mat_b : base_r;

    matrix_mul #(.N(N)) u_mul_acc (
        .a (mul_a),
        .b (mul_b),
        .p (prod_ab)
    );

    matrix_mul #(.N(N)) u_mul_sq (
        .a (base_r),
        .b (base_r),
        .p (prod_sq)
    );

    // State register; reset abandons any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: RUN ends on the edge whose shifted exponent reaches zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (in_op && (in_exp != '0)) ? RUN : DONE;
            RUN:  if (exp_shift == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: load on accept, one square-and-multiply step per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0;
            acc_r  <= '0;
            exp_r  <= '0;
        end else if (accept) begin
            acc_r <= in_op ? ident : prod_ab;
            if (in_op && (in_exp != '0)) begin
                base_r <= in_mat_a;
                exp_r  <= in_exp;
            end
        end else if (state_q == RUN) begin
            if (exp_r[0]) acc_r <= prod_ab;
            base_r <= prod_sq;
            exp_r  <= exp_shift;
        end
    end

    // Outputs decoded from state; the result is only visible in DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        out_mat   = (state_q == DONE) ? acc_r : '0;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_gf2_matrix_pow.sv
// Directed bench for gf2_matrix_pow (N=4, EXP_W=16): products, powers,
// latency, backpressure and asynchronous reset in the middle of a power.
module tb_gf2_matrix_pow;
    import gf2_pkg::*;

    localparam int N     = 4;
    localparam int EXP_W = 16;
    localparam int W     = N * N;

    // Hand-derived matrices (row-major, element (0,0) is the leftmost hex bit).
    localparam logic [W-1:0] M_I   = 16'h8421; // identity
    localparam logic [W-1:0] M_J   = 16'h4210; // superdiagonal shift
    localparam logic [W-1:0] M_J2  = 16'h2100; // J^2
    localparam logic [W-1:0] M_C   = 16'h1942; // companion of x^4+x+1
    localparam logic [W-1:0] M_C5  = 16'h3AD6; // columns x^5..x^8 mod p
    localparam logic [W-1:0] M_C10 = 16'hBEF7; // columns x^10..x^13 mod p

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [0:W-1]     in_mat_a;
    logic [0:W-1]     in_mat_b;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [0:W-1]     out_mat;
    logic             busy;
    state_t           state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] obs5;
    logic [W-1:0] obs10;

    gf2_matrix_pow #(.N(N), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_mat_a  (in_mat_a),
        .in_mat_b  (in_mat_b),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mat   (out_mat),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a request on the next falling edge; it is accepted on the following rising edge.
    task automatic send_req(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [EXP_W-1:0] e, input logic [W-1:0] expm);
        exp_q.push_back(expm);
        @(negedge clk);
        check("ready_before_req", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_mat_a = a;
        in_mat_b = b;
        in_exp   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid, then score the result.
    task automatic wait_result(input string tag, input int lat, output logic [W-1:0] res);
        int edges;
        logic [W-1:0] expm;
        edges = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_lat"}, edges, lat);
        expm = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_mat"}, {16'd0, out_mat}, {16'd0, expm});
        res = out_mat;
    endtask

    // Take the result and confirm the engine is back in IDLE.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_mat"}, {16'd0, out_mat}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_mat_a  = '0;
        in_mat_b  = '0;
        in_exp    = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_mat", {16'd0, out_mat}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_state", {30'd0, state_dbg}, {30'd0, IDLE});

        // Single product I x J = J, result right after accept
        send_req(1'b0, M_I, M_J, 16'd0, M_J);
        wait_result("mul_i_j", 0, obs);
        check("mul_busy", {31'd0, busy}, 32'd1);
        consume("mul_i_j");

        // Powers of the nilpotent shift J
        send_req(1'b1, M_J, 16'hFFFF, 16'd2, M_J2);
        wait_result("pow_j2", 2, obs);
        consume("pow_j2");
        send_req(1'b1, M_J, 16'h0000, 16'd4, 16'h0000);
        wait_result("pow_j4", 3, obs);
        consume("pow_j4");
        send_req(1'b1, M_J, 16'h0000, 16'd0, M_I);
        wait_result("pow_j0", 0, obs);
        consume("pow_j0");

        // Companion matrix of a primitive polynomial: order 15
        send_req(1'b1, M_C, 16'h0000, 16'd15, M_I);
        wait_result("pow_c15", 4, obs);
        consume("pow_c15");
        send_req(1'b1, M_C, 16'h0000, 16'd5, M_C5);
        wait_result("pow_c5", 3, obs5);
        check("pow_c5_not_i", {31'd0, obs5 != M_I}, 32'd1);
        consume("pow_c5");
        send_req(1'b1, M_C, 16'h0000, 16'd10, M_C10);
        wait_result("pow_c10", 4, obs10);
        check("pow_c10_not_i", {31'd0, obs10 != M_I}, 32'd1);
        consume("pow_c10");
        send_req(1'b0, obs5, obs10, 16'd0, M_I);
        wait_result("mul_c5_c10", 0, obs);
        consume("mul_c5_c10");

        // Backpressure: result held, ready low, stray requests ignored
        send_req(1'b1, M_J, 16'h0000, 16'd2, M_J2);
        wait_result("bp", 2, obs);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_mat", {16'd0, out_mat}, {16'd0, M_J2});
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = (c == 1 || c == 3);
            in_op    = 1'b0;
            in_mat_a = M_I;
            in_mat_b = M_I;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_after_pulses_mat", {16'd0, out_mat}, {16'd0, M_J2});
        consume("bp");
        @(negedge clk);
        check("bp_no_stray_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset after 7 steps of a long power
        send_req(1'b1, M_C, 16'h0000, 16'hFFFF, 16'h0000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("midrun_busy", {31'd0, busy}, 32'd1);
        check("midrun_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_mat", {16'd0, out_mat}, 32'd0);
        exp_q.delete(); // the aborted power never produces a result
        @(negedge clk);
        rst_n = 1'b1;
        send_req(1'b1, M_I, 16'h0000, 16'd3, M_I);
        wait_result("rst_recover", 2, obs);
        consume("rst_recover");

        // Report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf2_matrix_pow.md
Name: gf2_matrix_pow

Overview:
- Sequential GF(2) matrix engine. Computes either a single product A·B or a power A^e over GF(2) using right-to-left square-and-multiply, one step per clock.
- Used by the switching generator to build jump-ahead (state-transition) matrices for LFSR/switching sequences.
- Matrices are flat vectors: row-major, element (i,j) at bit i*N+j, vector declared [0:N*N-1].
- Entries are added with XOR and multiplied with AND.

Parameters:
- N, 4: matrix dimension (N×N bits). Legal range N ≥ 2.
- EXP_W, 16: exponent width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  engine can accept a request.
- in_op  input  1  operation select: 0 = multiply (A·B), 1 = power (A^e).
- in_mat_a  input  [0:N*N-1]  operand A (base for power).
- in_mat_b  input  [0:N*N-1]  operand B (ignored when in_op=1).
- in_exp  input  EXP_W  exponent e (ignored when in_op=0).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_mat  output  [0:N*N-1]  result matrix.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Registers: base_r, acc_r (each N*N bits), exp_r (EXP_W bits), state.
- Reset (asynchronous, while rst_n=0), from any state including mid-RUN:
  - state=IDLE; base_r, acc_r, exp_r cleared to 0.
  - in_ready=1, out_valid=0, out_mat=0, busy=0.
  - Any in-flight computation is discarded; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1. A request is accepted on a clock edge where in_valid=1.
  - in_op=0: acc_r←A·B (combinational product). Next state DONE.
  - in_op=1, e=0: acc_r←I. Next state DONE.
  - in_op=1, e≠0: acc_r←I, base_r←A, exp_r←e. Next state RUN.
- RUN, one step per edge:
  - if exp_r[0]=1, acc_r←acc_r·base_r.
  - base_r←base_r·base_r.
  - exp_r←exp_r>>1.
  - When the shifted exponent is 0, next state is DONE on that same edge.
- Latency, counted from the accepting edge to out_valid high:
  - multiply or e=0: valid directly after the accepting edge (0 extra edges).
  - power with e≠0: L further edges, where L = floor(log2 e)+1. Example: e=5 → 3 edges; e=2^EXP_W−1 → EXP_W edges.
- DONE:
  - out_valid=1; out_mat=acc_r, held stable until a handshake edge.
  - On an edge with out_ready=1, the result is consumed: next state IDLE and out_valid drops.
  - in_ready=0 throughout DONE and RUN. A new request can be accepted at the earliest on the edge after the handshake edge; there is no overlap.
- out_mat drives acc_r only in DONE; otherwise it is 0.
- in_valid asserted while in_ready=0 is ignored. The requester must hold its request until in_ready is seen.
- Width rules: every product bit is (i,j) = XOR over k of A(i,k)&B(k,j). There are no carries and no overflow.
- Exponent wrap: none. e is an unsigned EXP_W-bit value, and the engine always terminates within EXP_W steps.

Decomposition:
- Shared package gf2_pkg:
  - function for the index of element (i,j), i.e. i*N+j;
  - identity-matrix constant generator;
  - state encoding localparams IDLE/RUN/DONE.
- Sub-module: instantiate the existing combinational GF(2) multiplier matrix_mul twice:
  - one for acc_r·base_r (with in_mat_a·in_mat_b muxed in during IDLE);
  - one for base_r·base_r.
- No other sub-modules.

Test Plan:
- Reset in IDLE, then release → in_ready=1, out_valid=0, busy=0, out_mat=0x0000.
- N=4, op=0, A=I=0x8421, B=J=0x4210 (superdiagonal) → out_mat=0x4210, out_valid high directly after the accepting edge.
- N=4, op=1, A=J:
  - e=2 → 0x2100 after 2 edges;
  - e=4 → 0x0000 after 3 edges;
  - e=0 → 0x8421 immediately.
- N=4, op=1, A=companion matrix of x^4+x+1:
  - e=15 → 0x8421 after 4 edges;
  - e=5 and e=10 → both results ≠0x8421, and their product (recomputed via op=0) equals 0x8421.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_mat stable, in_ready=0, and in_valid pulses are ignored. The handshake edge gives IDLE on the next cycle.
- Assert rst_n=0 mid-RUN (e=0xFFFF, after 7 steps) → out_valid=0 and busy=0 immediately. The next request, op=1, A=I, e=3, returns 0x8421 after 2 edges.
